// File: rtl/prog_clock_divider.sv
// prog_clock_divider: NCH runtime-programmable dividers of clk plus a wrap-aligned dclk selector; all outputs registered.
// A divisor write is held pending (cfg_ready low) until its channel wraps. Define CLKDIV_DUTY50_EN for div>>1 high phase.
module prog_clock_divider #(
  parameter int NCH     = 4,
  parameter int CW      = 8,
  parameter int DEF_DIV = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [CW-1:0]          cfg_div,
  input  logic [$clog2(NCH)-1:0] sel,
  output logic [$clog2(NCH)-1:0] sel_act,
  output logic [NCH-1:0]         clk_out,
  output logic [NCH-1:0]         tick,
  output logic                   dclk
);
  localparam int            SW  = $clog2(NCH);
  localparam logic [CW-1:0] DEF = CW'(DEF_DIV);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] TWO = CW'(2);

  logic [CW-1:0]  cnt_q  [NCH];
  logic [CW-1:0]  cnt_d  [NCH];
  logic [CW-1:0]  div_q  [NCH];
  logic [CW-1:0]  div_d  [NCH];
  logic [CW-1:0]  pdiv_q [NCH];
  logic [CW-1:0]  pdiv_d [NCH];
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] wrap;
  logic [NCH-1:0] clk_q, clk_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic [SW-1:0]  sel_q, sel_d;
  logic           dclk_q, dclk_d;
  logic           cfg_ch_ok, cfg_acc;
  logic [CW-1:0]  cfg_div_sat;
  logic [CW-1:0]  hi;

  always_comb begin
    cfg_ch_ok   = int'(cfg_ch) < NCH;
    cfg_ready   = cfg_ch_ok && !pend_q[cfg_ch];
    cfg_acc     = cfg_valid && cfg_ready;
    cfg_div_sat = (cfg_div < TWO) ? TWO : cfg_div;
  end

  always_comb begin
    hi     = ONE;
    pend_d = pend_q;
    for (int i = 0; i < NCH; i++) begin
      wrap[i]   = (cnt_q[i] == div_q[i] - ONE);
      cnt_d[i]  = wrap[i] ? '0 : cnt_q[i] + ONE;
      div_d[i]  = div_q[i];
      pdiv_d[i] = pdiv_q[i];
      // A pending divisor only takes effect on a period boundary.
      if (wrap[i] && pend_q[i]) begin
        div_d[i]  = pdiv_q[i];
        pend_d[i] = 1'b0;
      end
      // Accept requires pend_q low, so it can never collide with an apply above.
      if (cfg_acc && int'(cfg_ch) == i) begin
        pdiv_d[i] = cfg_div_sat;
        pend_d[i] = 1'b1;
      end
`ifdef CLKDIV_DUTY50_EN
      hi = div_d[i] >> 1;
`else
      hi = ONE;
`endif
      clk_d[i]  = cnt_d[i] < hi;
      tick_d[i] = cnt_d[i] == '0;
    end
  end

  // Switching only when the current source wraps lands the change on its rising edge.
  always_comb begin
    sel_d = sel_q;
    if (sel != sel_q && int'(sel) < NCH && wrap[sel_q]) sel_d = sel;
    dclk_d = clk_d[sel_d];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= DEF;
        pdiv_q[i] <= DEF;
      end
      pend_q <= '0;
      clk_q  <= '1;
      tick_q <= '0;
      sel_q  <= '0;
      dclk_q <= 1'b1;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        div_q[i]  <= div_d[i];
        pdiv_q[i] <= pdiv_d[i];
      end
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      sel_q  <= sel_d;
      dclk_q <= dclk_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign sel_act = sel_q;
  assign dclk    = dclk_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Bench for prog_clock_divider: hand-written vector table, a spec model feeding a scoreboard queue,
// and directed sequences for pending writes, divisor saturation, selector timing and mid-run reset.
module tb_prog_clock_divider;

  typedef struct packed {
    logic [3:0] clk;
    logic [3:0] tick;
    logic [1:0] sel;
    logic       dclk;
  } exp_t;

  typedef struct {
    bit   rv;
    bit   cv;
    int   ch;
    int   dv;
    exp_t e;
  } vec_t;

  logic       clk, rst_n, cfg_valid, cfg_ready, dclk;
  logic [1:0] cfg_ch, sel, sel_act;
  logic [7:0] cfg_div;
  logic [3:0] clk_out, tick;

  logic       cfg_valid3, cfg_ready3, dclk3;
  logic [1:0] cfg_ch3, sel3, sel_act3;
  logic [7:0] cfg_div3;
  logic [2:0] clk_out3, tick3;

  prog_clock_divider #(.NCH(4), .CW(8), .DEF_DIV(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .sel(sel), .sel_act(sel_act),
    .clk_out(clk_out), .tick(tick), .dclk(dclk)
  );

  // Three-channel instance: cfg_ch/sel value 3 is out of range here.
  prog_clock_divider #(.NCH(3), .CW(8), .DEF_DIV(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
    .cfg_ch(cfg_ch3), .cfg_div(cfg_div3), .sel(sel3), .sel_act(sel_act3),
    .clk_out(clk_out3), .tick(tick3), .dclk(dclk3)
  );

  int   n_pass = 0;
  int   n_chk  = 0;
  exp_t sbq[$];
  vec_t tab[13];

  int   m_cnt[4], m_div[4], m_pdiv[4];
  bit   m_pend[4];
  int   m_sel;
  bit   m_valid = 0;
  int   cyc3;
  int   cur_sel = 0;

  bit         obs_rdy;
  logic [3:0] obs_clk, obs_tick;
  logic [1:0] obs_sel;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  function automatic int hi_of(input int d);
`ifdef CLKDIV_DUTY50_EN
    return d / 2;
`else
    return 1;
`endif
  endfunction

  function automatic vec_t mk(input bit rv, input bit cv, input int ch, input int dv,
                              input logic [3:0] c, input logic [3:0] t, input logic d);
    vec_t v;
    v.rv = rv; v.cv = cv; v.ch = ch; v.dv = dv;
    v.e.clk = c; v.e.tick = t; v.e.sel = 2'd0; v.e.dclk = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic step(input bit rv, input bit cv, input int ch, input int dv, input int sl,
                      input bit use_tab, input exp_t tab_exp);
    exp_t     e, x;
    bit [3:0] w;
    bit       acc;
    @(negedge clk);
    rst_n = rv; cfg_valid = cv; cfg_ch = ch[1:0]; cfg_div = dv[7:0]; sel = sl[1:0];
    #1;
    obs_rdy = cfg_ready;
    if (m_valid) chk("cfg_ready", cfg_ready, m_pend[ch] ? 0 : 1);
    chk("u3_cfg_ready", cfg_ready3, 0);
    e = '0;
    if (!rv) begin
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] = 0; m_div[i] = 2; m_pend[i] = 0;
      end
      m_sel = 0; m_valid = 1; cyc3 = 0;
      e.clk = 4'hF; e.tick = 4'h0; e.sel = 2'd0; e.dclk = 1'b1;
    end else begin
      acc = cv && !m_pend[ch];
      for (int i = 0; i < 4; i++) w[i] = (m_cnt[i] == m_div[i] - 1);
      if (sl != m_sel && w[m_sel]) m_sel = sl;
      for (int i = 0; i < 4; i++) begin
        if (w[i]) begin
          m_cnt[i] = 0;
          if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 0; end
        end else m_cnt[i] = m_cnt[i] + 1;
      end
      if (acc) begin m_pdiv[ch] = (dv < 2) ? 2 : dv; m_pend[ch] = 1; end
      for (int i = 0; i < 4; i++) begin
        e.clk[i]  = m_cnt[i] < hi_of(m_div[i]);
        e.tick[i] = m_cnt[i] == 0;
      end
      e.sel  = 2'(m_sel);
      e.dclk = e.clk[m_sel];
      cyc3++;
    end
    sbq.push_back(use_tab ? tab_exp : e);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    chk("clk_out", clk_out, x.clk);
    chk("tick", tick, x.tick);
    chk("sel_act", sel_act, x.sel);
    chk("dclk", dclk, x.dclk);
    chk("u3_clk_out", clk_out3, (cyc3 % 2 == 0) ? 3 'b111 : 3'b000);
    chk("u3_tick", tick3, (cyc3 != 0 && cyc3 % 2 == 0) ? 3'b111 : 3'b000);
    chk("u3_sel_act", sel_act3, 0);
    obs_clk = clk_out; obs_tick = tick; obs_sel = sel_act;
  endtask

  task automatic step_idle(input int ch);
    step(1'b1, 1'b0, ch, 0, cur_sel, 1'b0, '0);
  endtask

  task automatic write_cfg(input int ch, input int dv);
    bit done = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      step(1'b1, 1'b1, ch, dv, cur_sel, 1'b0, '0);
      if (obs_rdy) done = 1;
    end
    chk("write_accept_timeout", done, 1);
  endtask

  task automatic wait_apply(input int ch);
    bit done = 0;
    for (int k = 0; k < 600 && !done; k++) begin
      step_idle(ch);
      if (obs_rdy) done = 1;
    end
    chk("apply_timeout", done, 1);
  endtask

  task automatic wait_tick(input int ch);
    bit got = 0;
    for (int k = 0; k < 600 && !got; k++) begin
      step_idle(ch);
      if (obs_tick[ch]) got = 1;
    end
    chk("tick_timeout", got, 1);
  endtask

  task automatic measure(input int ch, output int period, output int high);
    bit got = 0;
    period = 0; high = 0;
    wait_tick(ch);
    for (int k = 0; k < 600 && !got; k++) begin
      period++;
      if (obs_clk[ch]) high++;
      step_idle(ch);
      if (obs_tick[ch]) got = 1;
    end
    chk("measure_timeout", got, 1);
  endtask

  task automatic run_random();
    bit rv, cv;
    int ch, dv;
    for (int k = 0; k < 400; k++) begin
      rv = ($urandom_range(0, 99) != 0);
      cv = ($urandom_range(0, 3) == 0);
      ch = $urandom_range(0, 3);
      dv = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 12);
      if ($urandom_range(0, 5) == 0) cur_sel = $urandom_range(0, 3);
      step(rv, cv, ch, dv, cur_sel, 1'b0, '0);
    end
  endtask

  initial begin
    int  p, h, n;
    bit  got;
    cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_div3 = 8'd5; sel3 = 2'd3;

    // Reset and default /2 waveform; ch1=3 written on a wrap cycle applies one wrap later.
    tab[0]  = mk(0, 0, 0, 0, 4'hF, 4'h0, 1'b1);
    tab[1]  = mk(0, 0, 0, 0, 4'hF, 4'h0, 1'b1);
    tab[2]  = mk(1, 0, 0, 0, 4'h0, 4'h0, 1'b0);
    tab[3]  = mk(1, 0, 0, 0, 4'hF, 4'hF, 1'b1);
    tab[4]  = mk(1, 0, 0, 0, 4'h0, 4'h0, 1'b0);
    tab[5]  = mk(1, 0, 0, 0, 4'hF, 4'hF, 1'b1);
    tab[6]  = mk(1, 0, 0, 0, 4'h0, 4'h0, 1'b0);
    tab[7]  = mk(1, 1, 1, 3, 4'hF, 4'hF, 1'b1);
    tab[8]  = mk(1, 0, 1, 0, 4'h0, 4'h0, 1'b0);
    tab[9]  = mk(1, 0, 1, 0, 4'hF, 4'hF, 1'b1);
    tab[10] = mk(1, 0, 1, 0, 4'h0, 4'h0, 1'b0);
    tab[11] = mk(1, 0, 1, 0, 4'hD, 4'hD, 1'b1);
    tab[12] = mk(1, 0, 1, 0, 4'h2, 4'h2, 1'b0);
    for (int i = 0; i < 13; i++)
      step(tab[i].rv, tab[i].cv, tab[i].ch, tab[i].dv, 0, 1'b1, tab[i].e);

    // Periods 3 / 8 / 4.
    write_cfg(2, 8);
    write_cfg(3, 4);
    for (int k = 0; k < 10; k++) step_idle(0);
    measure(1, p, h); chk("t2_ch1_period", p, 3); chk("t2_ch1_high", h, hi_of(3));
    measure(2, p, h); chk("t2_ch2_period", p, 8); chk("t2_ch2_high", h, hi_of(8));
    measure(3, p, h); chk("t2_ch3_period", p, 4); chk("t2_ch3_high", h, hi_of(4));

    // Mid-period write: current 5-cycle period completes, then 7.
    write_cfg(0, 5);
    wait_apply(0);
    wait_tick(0);
    step_idle(0);
    step_idle(0);
    step(1'b1, 1'b1, 0, 7, cur_sel, 1'b0, '0);
    chk("t3_accept", obs_rdy, 1);
    n = 3; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      step_idle(0);
      n++;
      chk("t3_rdy_low", obs_rdy, 0);
      if (obs_tick[0]) got = 1;
    end
    chk("t3_old_period", n, 5);
    n = 0; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      n++;
      step_idle(0);
      if (k == 0) chk("t3_rdy_high", obs_rdy, 1);
      if (obs_tick[0]) got = 1;
    end
    chk("t3_new_period", n, 7);

    // Divisors 0 and 1 saturate to 2.
    write_cfg(2, 0);
    wait_apply(2);
    measure(2, p, h); chk("t4_div0_period", p, 2);
    write_cfg(2, 1);
    wait_apply(2);
    measure(2, p, h); chk("t4_div1_period", p, 2);

    // Selector 0->3 with ch0 div=6 requested at cnt=2.
    write_cfg(0, 6);
    wait_apply(0);
    wait_tick(0);
    step_idle(0);
    step_idle(0);
    cur_sel = 3;
    for (int k = 0; k < 3; k++) begin
      step_idle(0);
      chk("t5_sel_hold", obs_sel, 0);
    end
    step_idle(0);
    chk("t5_sel_switch", obs_sel, 3);
    chk("t5_switch_on_wrap", obs_tick[0], 1);

    // One-cycle reset with a write still pending.
    write_cfg(1, 9);
    step(1'b0, 1'b0, 1, 0, cur_sel, 1'b0, '0);
    chk("t6_clk_out", obs_clk, 4'hF);
    chk("t6_tick", obs_tick, 4'h0);
    chk("t6_sel_act", obs_sel, 0);
    chk("t6_dclk", dclk, 1);
    cur_sel = 0;
    step_idle(1);
    chk("t6_cfg_ready", obs_rdy, 1);
    chk("t6_clk_low", obs_clk, 4'h0);
    measure(1, p, h); chk("t6_ch1_period", p, 2);

    run_random();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
